// File: rtl/dnn_vec_sender_pkg.sv
// rtl/dnn_vec_sender_pkg.sv - shared defaults, FSM encoding and width helper for the DNN vector sender
package dnn_vec_sender_pkg;

    localparam int DW_DEF    = 20;
    localparam int NFEAT_DEF = 39;
    localparam int GAP_DEF   = 20;

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    // Bits needed to count 0..maxval, never less than one so GAP=0 still has a counter.
    function automatic int cnt_width(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/dnn_vec_sender_if.sv
// rtl/dnn_vec_sender_if.sv - feature write port and DNN vector output bundle
interface dnn_vec_sender_if #(
    parameter int DW = dnn_vec_sender_pkg::DW_DEF
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [DW-1:0] vec_out;
    logic          dv_out;
    logic          sof_out;
    logic          eof_out;

    modport master (
        output wr_en, wr_data,
        input  wr_ready, vec_out, dv_out, sof_out, eof_out
    );

    modport slave (
        input  wr_en, wr_data,
        output wr_ready, vec_out, dv_out, sof_out, eof_out
    );

endinterface

// File: rtl/dnn_feat_ram.sv
// rtl/dnn_feat_ram.sv - NFEAT x DW feature buffer, one write port, asynchronous read port
module dnn_feat_ram
    import dnn_vec_sender_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NFEAT = NFEAT_DEF,
    parameter int AW    = (NFEAT < 2) ? 1 : $clog2(NFEAT)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [NFEAT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dnn_vec_sender.sv
// rtl/dnn_vec_sender.sv - buffers one frame of features, then plays it to the DNN with GAP idle cycles between words
module dnn_vec_sender
    import dnn_vec_sender_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NFEAT = NFEAT_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic             clk,
    input  logic             reset,
    dnn_vec_sender_if.slave  vs,
    output logic             busy,
    output logic             overflow
);

    localparam int PW = cnt_width(NFEAT);
    localparam int GW = cnt_width(GAP);
    localparam int AW = (NFEAT < 2) ? 1 : $clog2(NFEAT);

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] vec_q, vec_d;
    logic          dv_q, dv_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic          ovf_q, ovf_d;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    dnn_feat_ram #(
        .DW    (DW),
        .NFEAT (NFEAT),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (vs.wr_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            gap_q    <= '0;
            vec_q    <= '0;
            dv_q     <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            gap_q    <= gap_d;
            vec_q    <= vec_d;
            dv_q     <= dv_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        gap_d    = gap_q;
        vec_d    = vec_q;
        dv_d     = 1'b0;
        sof_d    = 1'b0;
        eof_d    = 1'b0;
        ram_we   = 1'b0;
        ovf_d    = ovf_q | (vs.wr_en & (state_q != FILL));

        case (state_q)
            FILL: begin
                if (vs.wr_en) begin
                    ram_we = 1'b1;
                    if (wr_ptr_q == PW'(NFEAT - 1)) begin
                        state_d  = SEND;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        gap_d    = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            SEND: begin
                // The last pulse has to stay inside SEND, so the hand-back waits one edge.
                if (eof_q) begin
                    state_d = FILL;
                    gap_d   = '0;
                end else if (gap_q == GW'(GAP)) begin
                    vec_d    = ram_rdata;
                    dv_d     = 1'b1;
                    sof_d    = (rd_ptr_q == '0);
                    eof_d    = (rd_ptr_q == PW'(NFEAT - 1));
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    gap_d    = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign vs.wr_ready = (state_q == FILL);
    assign vs.vec_out  = vec_q;
    assign vs.dv_out   = dv_q;
    assign vs.sof_out  = sof_q;
    assign vs.eof_out  = eof_q;
    assign busy        = (state_q == SEND);
    assign overflow    = ovf_q;

endmodule

// File: doc/dnn_vec_sender.md
DNN_VEC_SENDER -- requirements
Module: dnn_vec_sender

Interface
REQ-001 Parameter DW, default 20: feature word width; matches the DNN vec_in port.
REQ-002 Parameter NFEAT, default 39: feature words per frame.
REQ-003 Parameter GAP, default 20: idle cycles between consecutive dv_out pulses.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  feature write strobe, accepted only when wr_ready=1.
REQ-007 wr_data  input  DW  feature word, written in order feature 0..NFEAT-1.
REQ-008 wr_ready  output  1  high while the block is filling its buffer.
REQ-009 vec_out  output  DW  feature word presented to the DNN vec_in port.
REQ-010 dv_out  output  1  one-cycle valid pulse qualifying vec_out; drives the DNN dv_in port.
REQ-011 sof_out  output  1  high together with dv_out for feature 0 only.
REQ-012 eof_out  output  1  high together with dv_out for feature NFEAT-1 only.
REQ-013 busy  output  1  high while in the SEND state.
REQ-014 overflow  output  1  sticky flag: a write was attempted while wr_ready=0.

Function
REQ-015 FSM states: FILL and SEND; the state is FILL after reset.
REQ-016 FILL behaviour:
- wr_ready=1.
- Each wr_en stores wr_data at buffer[wr_ptr] and increments wr_ptr.
REQ-017 FILL exit: the write that brings wr_ptr to NFEAT moves the FSM to SEND on the next edge.
- On that edge wr_ptr clears to 0, rd_ptr=0 and gap_cnt=0.
REQ-018 SEND behaviour:
- wr_ready=0.
- gap_cnt increments every cycle.
- When gap_cnt reaches GAP: vec_out is registered from buffer[rd_ptr], dv_out pulses for one cycle, rd_ptr increments and gap_cnt clears.
REQ-019 The first dv_out appears GAP+1 cycles after the edge that accepted the last write; consecutive dv_out pulses are exactly GAP+1 cycles apart.
REQ-020 After the pulse for rd_ptr=NFEAT-1 (eof_out=1), the FSM returns to FILL on the next edge.
- busy falls and wr_ready rises in that cycle.
REQ-021 vec_out holds its last value between pulses and is never X after reset.
REQ-022 dv_out, sof_out and eof_out are registered outputs and are never high outside SEND.
REQ-023 A wr_en while wr_ready=0 is ignored and sets overflow; overflow clears only on reset.
REQ-024 Pointer widths are clog2(NFEAT+1) bits; gap_cnt width is clog2(GAP+1) bits; there is no wrap beyond NFEAT.
REQ-025 Simultaneous wr_en on the cycle the FSM returns to FILL (wr_ready just risen) is accepted as feature 0 of the next frame.
REQ-026 NFEAT=1: the single dv_out has sof_out=eof_out=1.

Reset
REQ-027 On reset=0, asynchronously:
- state=FILL; wr_ptr, rd_ptr and gap_cnt=0.
- vec_out=0; dv_out, sof_out, eof_out, busy and overflow=0.
- wr_ready=1 on the first cycle after release.
REQ-028 Reset asserted mid-SEND aborts the frame with no further dv_out; the buffer contents need not be cleared.

Structure
REQ-029 A shared package holds DW, NFEAT and GAP defaults and the FSM state encoding (FILL=0, SEND=1).
REQ-030 The buffer is one sub-module, dnn_feat_ram: NFEAT x DW, one write port and one read port, asynchronous read; vec_out is registered in the top level.

Verification
REQ-031 Scenario: reset, then write 39 words with value i+1 on consecutive cycles.
- dv_out pulses 39 times, 21 cycles apart.
- vec_out = 1..39.
- sof_out on the 1st pulse, eof_out on the 39th.
REQ-032 Scenario: write words spaced by 3 idle cycles.
- No dv_out until the 39th write.
- The first dv_out exactly 21 cycles after that write.
REQ-033 Scenario: wr_en held high during SEND.
- overflow=1.
- Emitted vectors are unchanged from the filled frame.
- wr_ready=1 one cycle after eof_out.
REQ-034 Scenario: reset pulsed low after the 10th dv_out.
- Outputs go to reset values immediately.
- No dv_out follows.
- A new 39-word fill plays out correctly.
REQ-035 Scenario: two frames back-to-back, with frame 2 feature 0 written on the first wr_ready cycle.
- Frame 2 plays values 101..139 with correct sof_out/eof_out.
REQ-036 Scenario: GAP=0, NFEAT=1 build.
- A single write gives one dv_out with sof_out=eof_out=1 on the next cycle.
